data_mem_arbiter: RTL

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each access takes three cycles: grant in IDLE, memory strobe in ACCESS, ack in RESP.
module data_mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [DATA_W-1:0] mem_rd
);

  // state  | meaning
  // IDLE   | sample requests, latch the winner's command
  // ACCESS | drive the memory strobe for the latched command
  // RESP   | pulse ack to the latched requester

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_nxt;
  logic                last_grant;
  logic                lat_id;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wd;
  logic [DATA_W-1:0]   rdata_q;
  logic                grant_vld;
  logic                grant_id;

  // On a tie, the requester not granted last time wins.
  always_comb begin
    grant_vld = req0 | req1;
    grant_id  = 1'b0;
    if (req0 && req1) begin
      grant_id = ~last_grant;
    end else if (req1) begin
      grant_id = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    mem_memwrite = 1'b0;
    mem_memread  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        busy         = 1'b1;
        mem_memwrite = lat_we;
        mem_memread  = ~lat_we;
        state_nxt    = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        ack0      = ~lat_id;
        ack1      = lat_id;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      lat_id     <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wd     <= '0;
      rdata_q    <= '0;
    end else begin
      if (state == IDLE && grant_vld) begin
        last_grant <= grant_id;
        lat_id     <= grant_id;
        lat_we     <= grant_id ? we1 : we0;
        lat_addr   <= grant_id ? addr1 : addr0;
        lat_wd     <= grant_id ? wd1 : wd0;
      end
      if (state == ACCESS && !lat_we) begin
        rdata_q <= mem_rd;
      end
    end
  end

  assign mem_addr = lat_addr;
  assign mem_wd   = lat_wd;
  assign rdata    = rdata_q;

endmodule
